// File: rtl/lockin_demodulator.sv
// Dual-phase lock-in demodulator: square-wave I/Q references, 2^LOG2_N sample
// integration window, X/Y results on a valid/ready handshake.
module lockin_demodulator #(
    parameter int SAMPLE_W   = 8,
    parameter int LOG2_N     = 8,
    parameter int REF_PERIOD = 16,
    parameter int ACC_W      = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_W-1:0]     sample_in,
    input  logic                    sample_valid,
    input  logic                    ref_sync,
    output logic                    ref_out,
    output logic signed [ACC_W-1:0] x_out,
    output logic signed [ACC_W-1:0] y_out,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    overrun
);

    localparam int PH_W   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int TERM_W = SAMPLE_W + 2;

    localparam logic [PH_W-1:0] P_LAST = PH_W'(REF_PERIOD - 1);
    localparam logic [PH_W-1:0] P_HALF = PH_W'(REF_PERIOD / 2);
    localparam logic [PH_W-1:0] P_Q1   = PH_W'(REF_PERIOD / 4);
    localparam logic [PH_W-1:0] P_Q3   = PH_W'((3 * REF_PERIOD) / 4);

    localparam logic [LOG2_N-1:0]        C_LAST = '1;
    localparam logic signed [TERM_W-1:0] P_MID  = TERM_W'(2 ** (SAMPLE_W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_INTEGRATE,
        S_DUMP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PH_W-1:0]           r_phase;
    logic [LOG2_N-1:0]         r_count;
    logic signed [ACC_W-1:0]   r_acc_x;
    logic signed [ACC_W-1:0]   r_acc_y;
    logic signed [ACC_W-1:0]   r_x;
    logic signed [ACC_W-1:0]   r_y;
    logic                      r_valid;
    logic                      r_overrun;
    logic                      r_ref;

    logic                      w_active;
    logic                      w_accept;
    logic                      w_dump;
    logic [PH_W-1:0]           w_phase_use;
    logic [PH_W-1:0]           w_phase_inc;
    logic [PH_W-1:0]           w_phase_next;
    logic                      w_sign_i;
    logic                      w_sign_q;
    logic signed [TERM_W-1:0]  w_term;
    logic signed [TERM_W-1:0]  w_prod_x;
    logic signed [TERM_W-1:0]  w_prod_y;
    logic signed [ACC_W-1:0]   w_ext_x;
    logic signed [ACC_W-1:0]   w_ext_y;

    assign w_active = enable && (r_state != S_IDLE);
    assign w_accept = w_active && sample_valid;
    assign w_dump   = enable && (r_state == S_DUMP);

    // A sync coincident with a sample makes that sample use phase 0.
    assign w_phase_use = ref_sync ? '0 : r_phase;
    assign w_phase_inc = (w_phase_use == P_LAST) ? '0 : w_phase_use + 1'b1;
    assign w_sign_i    = (w_phase_use < P_HALF);
    assign w_sign_q    = (w_phase_use >= P_Q1) && (w_phase_use < P_Q3);

    assign w_term   = $signed({2'b00, sample_in}) - P_MID;
    assign w_prod_x = w_sign_i ? w_term : -w_term;
    assign w_prod_y = w_sign_q ? w_term : -w_term;
    assign w_ext_x  = {{(ACC_W - TERM_W){w_prod_x[TERM_W-1]}}, w_prod_x};
    assign w_ext_y  = {{(ACC_W - TERM_W){w_prod_y[TERM_W-1]}}, w_prod_y};

    always_comb begin
        w_phase_next = r_phase;
        if (!w_active) begin
            w_phase_next = '0;
        end else if (sample_valid) begin
            w_phase_next = w_phase_inc;
        end else if (ref_sync) begin
            w_phase_next = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:      w_state_next = S_INTEGRATE;
            S_INTEGRATE: begin
                if (sample_valid && (r_count == C_LAST)) begin
                    w_state_next = S_DUMP;
                end
            end
            S_DUMP:      w_state_next = S_INTEGRATE;
            default:     w_state_next = S_IDLE;
        endcase
        if (!enable) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_ref   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_ref   <= (w_phase_next < P_HALF);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_count <= '0;
        end else if (!w_active) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_count <= '0;
        end else if (r_state == S_DUMP) begin
            // The DUMP-cycle sample opens the next window.
            r_acc_x <= w_accept ? w_ext_x : '0;
            r_acc_y <= w_accept ? w_ext_y : '0;
            r_count <= w_accept ? LOG2_N'(1) : '0;
        end else if (w_accept) begin
            r_acc_x <= r_acc_x + w_ext_x;
            r_acc_y <= r_acc_y + w_ext_y;
            r_count <= (r_count == C_LAST) ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_dump) begin
                r_x     <= r_acc_x;
                r_y     <= r_acc_y;
                r_valid <= 1'b1;
            end else if (r_valid && result_ready) begin
                r_valid <= 1'b0;
            end
            if (!enable) begin
                r_overrun <= 1'b0;
            end else if (w_dump && r_valid && !result_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign ref_out      = r_ref;
    assign x_out        = r_x;
    assign y_out        = r_y;
    assign result_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
